// File: rtl/e_fwd_scoreboard.sv
// e_fwd_scoreboard: E-stage operand forwarding with an outstanding-load scoreboard
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   e_valid, ld_e            E-stage lane valid / lane is a load
//   rs1_e, rs2_e, rd_e       E-stage source and destination registers (5 bits per lane)
//   src1_e, src2_e           register-file read data (XLEN per lane)
//   rd_m, res_m, wr_m, ld_m  M-stage destination, result, write enable, load flag
//   rd_w, res_w, wr_w        W-stage destination, result, write enable
//   resp_valid/rd/data       load data return
//   op1_e, op2_e             forwarded operands
//   stall_e                  hold the E stage this cycle
//   sb_busy, sb_count        busy bit per register and its popcount
//   sb_err                   sticky flag: response to a register that was not busy
module e_fwd_scoreboard #(
    parameter int LANES  = 2,
    parameter int XLEN   = 32,
    parameter int MAX_LD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      e_valid,
    input  logic [LANES*5-1:0]    rs1_e,
    input  logic [LANES*5-1:0]    rs2_e,
    input  logic [LANES*XLEN-1:0] src1_e,
    input  logic [LANES*XLEN-1:0] src2_e,
    input  logic [LANES*5-1:0]    rd_e,
    input  logic [LANES-1:0]      ld_e,
    input  logic [LANES*5-1:0]    rd_m,
    input  logic [LANES*5-1:0]    rd_w,
    input  logic [LANES*XLEN-1:0] res_m,
    input  logic [LANES*XLEN-1:0] res_w,
    input  logic [LANES-1:0]      wr_m,
    input  logic [LANES-1:0]      wr_w,
    input  logic [LANES-1:0]      ld_m,
    input  logic                  resp_valid,
    input  logic [4:0]            resp_rd,
    input  logic [XLEN-1:0]       resp_data,
    output logic [LANES*XLEN-1:0] op1_e,
    output logic [LANES*XLEN-1:0] op2_e,
    output logic                  stall_e,
    output logic [31:0]           sb_busy,
    output logic [4:0]            sb_count,
    output logic                  sb_err
);
    logic [31:0] busy_q, busy_d, set_mask, clr_mask;
    logic [4:0]  cnt_q, cnt_d, rd;
    logic        err_q, err_d, h, c, clr;
    int          n_ld;

    // Sources are applied lowest priority first so the last match wins;
    // ascending lane loops therefore give the highest lane index precedence.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] src);
        logic [XLEN-1:0] v;
        v = src;
        if (rs != 5'd0) begin
            for (int j = 0; j < LANES; j++)
                if (wr_w[j] && rd_w[j*5+:5] == rs) v = res_w[j*XLEN+:XLEN];
            if (resp_valid && resp_rd == rs) v = resp_data;
            for (int j = 0; j < LANES; j++)
                if (wr_m[j] && !ld_m[j] && rd_m[j*5+:5] == rs) v = res_m[j*XLEN+:XLEN];
        end
        return v;
    endfunction

    // A busy register is only safe to read when the response is returning it now.
    function automatic logic haz(input logic [4:0] rs);
        logic r;
        r = 1'b0;
        if (rs != 5'd0) begin
            for (int j = 0; j < LANES; j++)
                if (wr_m[j] && ld_m[j] && rd_m[j*5+:5] == rs) r = 1'b1;
            if (busy_q[rs] && !(resp_valid && resp_rd == rs)) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        op1_e    = '0;
        op2_e    = '0;
        h        = 1'b0;
        c        = 1'b0;
        rd       = '0;
        n_ld     = 0;
        set_mask = '0;
        clr      = resp_valid && busy_q[resp_rd];
        clr_mask = resp_valid ? (32'd1 << resp_rd) : 32'd0;
        for (int i = 0; i < LANES; i++) begin
            op1_e[i*XLEN+:XLEN] = fwd(rs1_e[i*5+:5], src1_e[i*XLEN+:XLEN]);
            op2_e[i*XLEN+:XLEN] = fwd(rs2_e[i*5+:5], src2_e[i*XLEN+:XLEN]);
            if (e_valid[i]) begin
                h = h | haz(rs1_e[i*5+:5]) | haz(rs2_e[i*5+:5]);
                if (ld_e[i]) begin
                    rd = rd_e[i*5+:5];
                    if (busy_q[rd] && !(resp_valid && resp_rd == rd)) c = 1'b1;
                    for (int k = i + 1; k < LANES; k++)
                        if (e_valid[k] && ld_e[k] && rd_e[k*5+:5] == rd) c = 1'b1;
                    if (rd != 5'd0) begin
                        n_ld        = n_ld + 1;
                        set_mask[rd] = 1'b1;
                    end
                end
            end
        end
        if (int'(cnt_q) - int'(clr) + n_ld > MAX_LD) c = 1'b1;
        // Issue conflicts are meaningless while the scoreboard is held in reset.
        stall_e   = h | (c & ~rst);
        // Set after clear so a same-cycle set and clear leaves the bit set.
        busy_d    = (busy_q & ~clr_mask) | (stall_e ? 32'd0 : set_mask);
        busy_d[0] = 1'b0;
        cnt_d     = '0;
        for (int i = 0; i < 32; i++) cnt_d = cnt_d + 5'(busy_d[i]);
        err_d     = err_q | (resp_valid && resp_rd != 5'd0 && !busy_q[resp_rd]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign sb_busy  = busy_q;
    assign sb_count = cnt_q;
    assign sb_err   = err_q;
endmodule

// File: doc/e_fwd_scoreboard.md
E_FWD_SCOREBOARD -- requirements
Module: e_fwd_scoreboard

Interface
REQ-001 The parameters SHALL be:
- LANES, default 2, number of issue lanes.
- XLEN, default 32, datapath width.
- MAX_LD, default 4, maximum outstanding loads (1..31).
REQ-002 The ports SHALL be (lane i occupies bits [i*5+:5] or [i*XLEN+:XLEN]):
- clk  in  1  clock; the block has this one clock only.
- rst  in  1  asynchronous, active-high reset.
- e_valid  in  LANES  E-stage lane valid.
- rs1_e, rs2_e  in  LANES*5  E-stage source register numbers.
- src1_e, src2_e  in  LANES*XLEN  register-file read data.
- rd_e  in  LANES*5  E-stage destination register.
- ld_e  in  LANES  E-stage lane is a load.
- rd_m, rd_w  in  LANES*5  M/W destination registers.
- res_m, res_w  in  LANES*XLEN  M/W result data.
- wr_m, wr_w  in  LANES  M/W register-write enables.
- ld_m  in  LANES  M-stage lane is a load (data not yet available).
- resp_valid  in  1  load data return strobe.
- resp_rd  in  5  destination register of the returned load.
- resp_data  in  XLEN  returned load data.
- op1_e, op2_e  out  LANES*XLEN  forwarded operands.
- stall_e  out  1  hold the E stage this cycle.
- sb_busy  out  32  outstanding-load scoreboard bit per register.
- sb_count  out  5  number of set sb_busy bits.
- sb_err  out  1  sticky: response to a non-busy register.

Function
REQ-003 Operand selection SHALL be combinational, per lane and per source, in this priority order:
- M lanes, highest lane index first; match requires rd==rs, rd!=0, wr_m=1 and ld_m=0.
- Load response; match requires resp_valid=1, resp_rd==rs and rs!=0.
- W lanes, highest lane index first; match requires rd==rs, rd!=0 and wr_w=1.
- Otherwise src*_e.
REQ-004 A source of x0 SHALL always yield src*_e, with no match and no stall contribution.
REQ-005 Hazard h SHALL assert for a valid lane when either condition holds:
- A source matches an M lane with wr_m=1 and ld_m=1.
- A source register has its sb_busy bit set and the load response does not bypass that register this cycle.
REQ-006 Issue conflict c SHALL assert when any valid lane with ld_e=1 meets any of these conditions:
- rd_e is already busy and not cleared this cycle (WAW).
- rd_e equals the rd_e of another valid load lane in the same bundle.
- Accepting the bundle's loads would exceed MAX_LD after this cycle's clear.
REQ-007 stall_e SHALL equal h OR c, combinationally.
REQ-008 On each clk edge with stall_e=0, every valid ld_e lane with rd_e!=0 SHALL set sb_busy[rd_e].
REQ-009 On each clk edge with resp_valid=1, sb_busy[resp_rd] SHALL clear.
REQ-010 A simultaneous set and clear of the same register SHALL leave the bit set.
REQ-011 A response with resp_rd not busy SHALL set sb_err, and sb_err SHALL hold until reset.
REQ-012 sb_busy[0] SHALL never set, and resp_rd==0 SHALL NOT set sb_err.
REQ-013 sb_count SHALL be a registered popcount equal to the popcount of sb_busy at all times.
REQ-014 sb_count SHALL never exceed MAX_LD.
REQ-015 Scoreboard updates SHALL take effect one cycle after the edge.
REQ-016 Forwarding and stall SHALL reflect the registered sb_busy plus the same-cycle resp bypass.

Reset
REQ-017 While rst=1, asynchronously:
- sb_busy SHALL be 0, sb_count SHALL be 0 and sb_err SHALL be 0.
- stall_e SHALL depend only on the M-stage load-use check.
REQ-018 Reset asserted mid-operation SHALL discard all outstanding loads.
REQ-019 Responses arriving after reset SHALL set sb_err unless the register has been re-busied.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Priority: rs1_e lane0=5; rd_m lane0=5, rd_m lane1=5 (res_m 0x11/0x22); rd_w lane1=5 (res_w 0x33) -> op1_e lane0=0x22, stall_e=0.
- Load-use in M: rd_m lane0=7, wr_m=1, ld_m=1; rs2_e lane1=7 -> stall_e=1. With rs2_e=0 instead -> stall_e=0 and op2_e=src2_e.
- Scoreboard lifecycle: ld_e lane0, rd_e=9, stall_e=0 -> next cycle sb_busy[9]=1, sb_count=1. A reader of x9 stalls until resp_valid with resp_rd=9 and resp_data=0xDEADBEEF, which forwards 0xDEADBEEF with stall_e=0 the same cycle.
- Capacity: MAX_LD=4 with 4 busy registers; new ld_e -> stall_e=1. The same cycle plus resp_valid to a busy register -> stall_e=0, and sb_count stays 4.
- Same-reg set/clear: busy x3, resp_rd=3, and a new load to x3 -> blocked by WAW (stall_e=0 only when the resp clears it). Issue it, and sb_busy[3] remains 1.
- Error and reset: resp_rd=12 not busy -> sb_err=1 persists. Assert rst asynchronously mid-cycle -> sb_busy=0, sb_count=0 and sb_err=0 immediately.
